// File: rtl/rvjtag_tap_dmi_gen.sv
// JTAG TAP and Debug Transport Module bridging the JTAG pins to a valid/ready
// DMI request channel, with outstanding-access tracking and sticky dmistat.
module rvjtag_tap_dmi_gen #(
    parameter int          AWIDTH      = 7,
    parameter int          IR_WIDTH    = 5,
    parameter logic [31:0] IDCODE_VAL  = 32'h0000_0001,
    parameter logic [3:0]  DTM_VERSION = 4'h1
) (
    input  logic              tck,
    input  logic              trst,
    input  logic              tms,
    input  logic              tdi,
    output logic              tdo,
    output logic              tdo_en,
    input  logic [2:0]        idle_hint,
    output logic              dmi_req_valid,
    input  logic              dmi_req_ready,
    output logic [AWIDTH-1:0] dmi_req_addr,
    output logic [31:0]       dmi_req_data,
    output logic [1:0]        dmi_req_op,
    input  logic              dmi_rsp_valid,
    input  logic [31:0]       dmi_rsp_data,
    input  logic [1:0]        dmi_rsp_status,
    output logic              dmi_reset,
    output logic              dmi_hard_reset
);

    localparam int          DMI_W = AWIDTH + 34;
    localparam int          SR_W  = (DMI_W > IR_WIDTH) ? DMI_W : IR_WIDTH;
    localparam logic [5:0]  ABITS = 6'(AWIDTH);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } tap_state_t;

    tap_state_t state, state_next;

    logic [IR_WIDTH-1:0] ir, ir_next;
    logic [SR_W-1:0]     sr, sr_next;
    logic [1:0]          sticky, sticky_rsp, sticky_next;
    logic                outstanding, outst_rsp, outstanding_next;
    logic [31:0]         rsp_data_q, rsp_data_rsp, rsp_data_next;
    logic                req_valid_next;
    logic [AWIDTH-1:0]   req_addr_next;
    logic [31:0]         req_data_next;
    logic [1:0]          req_op_next;
    logic                reset_pulse_next, hard_pulse_next;
    logic [1:0]          cap_status;
    logic [31:0]         dtmcs_cap;
    logic                sel_idcode, sel_dtmcs, sel_dmi;
    logic                rsp_accept;
    logic [1:0]          upd_op;

    assign sel_idcode = (ir == IR_WIDTH'(1));
    assign sel_dtmcs  = (ir == IR_WIDTH'(16));
    assign sel_dmi    = (ir == IR_WIDTH'(17));
    assign tdo_en     = (state == SH_DR) || (state == SH_IR);
    assign dtmcs_cap  = {14'b0, 2'b0, 1'b0, idle_hint, sticky, ABITS, DTM_VERSION};
    assign upd_op     = sr[1:0];

    always_comb begin
        state_next = state;
        case (state)
            TLR:      state_next = tms ? TLR    : RTI;
            RTI:      state_next = tms ? SEL_DR : RTI;
            SEL_DR:   state_next = tms ? SEL_IR : CAP_DR;
            CAP_DR:   state_next = tms ? EX1_DR : SH_DR;
            SH_DR:    state_next = tms ? EX1_DR : SH_DR;
            EX1_DR:   state_next = tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: state_next = tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   state_next = tms ? UPD_DR : SH_DR;
            UPD_DR:   state_next = tms ? SEL_DR : RTI;
            SEL_IR:   state_next = tms ? TLR    : CAP_IR;
            CAP_IR:   state_next = tms ? EX1_IR : SH_IR;
            SH_IR:    state_next = tms ? EX1_IR : SH_IR;
            EX1_IR:   state_next = tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: state_next = tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   state_next = tms ? UPD_IR : SH_IR;
            UPD_IR:   state_next = tms ? SEL_DR : RTI;
            default:  state_next = TLR;
        endcase
    end

    // An all-zero IR scan is promoted to all-ones so it selects BYPASS.
    always_comb begin
        ir_next = ir;
        if (state == TLR) begin
            ir_next = IR_WIDTH'(1);
        end else if (state == UPD_IR) begin
            ir_next = (sr[IR_WIDTH-1:0] == '0) ? '1 : sr[IR_WIDTH-1:0];
        end
    end

    // Response is applied first; capture and update logic below see its effect.
    always_comb begin
        rsp_accept   = dmi_rsp_valid && outstanding && !dmi_req_valid;
        sticky_rsp   = sticky;
        outst_rsp    = outstanding;
        rsp_data_rsp = rsp_data_q;
        if (rsp_accept) begin
            outst_rsp = 1'b0;
            if (dmi_req_op == 2'd1) begin
                rsp_data_rsp = dmi_rsp_data;
            end
            if ((dmi_rsp_status == 2'd2 || dmi_rsp_status == 2'd3) && sticky == 2'd0) begin
                sticky_rsp = dmi_rsp_status;
            end
        end
    end

    always_comb begin
        cap_status = 2'd0;
        if (sticky_rsp != 2'd0) begin
            cap_status = sticky_rsp;
        end else if (outst_rsp) begin
            cap_status = 2'd3;
        end
    end

    always_comb begin
        sr_next = sr;
        case (state)
            CAP_IR: sr_next = SR_W'(2'b01);
            SH_IR: begin
                sr_next = '0;
                sr_next[IR_WIDTH-1:0] = {tdi, sr[IR_WIDTH-1:1]};
            end
            CAP_DR: begin
                if (sel_idcode) begin
                    sr_next = SR_W'(IDCODE_VAL);
                end else if (sel_dtmcs) begin
                    sr_next = SR_W'(dtmcs_cap);
                end else if (sel_dmi) begin
                    sr_next = SR_W'({rsp_data_rsp, cap_status});
                end else begin
                    sr_next = '0;
                end
            end
            SH_DR: begin
                if (sel_idcode || sel_dtmcs) begin
                    sr_next = '0;
                    sr_next[31:0] = {tdi, sr[31:1]};
                end else if (sel_dmi) begin
                    sr_next = '0;
                    sr_next[DMI_W-1:0] = {tdi, sr[DMI_W-1:1]};
                end else begin
                    sr_next = SR_W'(tdi);
                end
            end
            default: sr_next = sr;
        endcase
    end

    always_comb begin
        sticky_next      = sticky_rsp;
        outstanding_next = outst_rsp;
        rsp_data_next    = rsp_data_rsp;
        req_valid_next   = dmi_req_valid;
        req_addr_next    = dmi_req_addr;
        req_data_next    = dmi_req_data;
        req_op_next      = dmi_req_op;
        reset_pulse_next = 1'b0;
        hard_pulse_next  = 1'b0;

        if (dmi_req_valid && dmi_req_ready) begin
            req_valid_next = 1'b0;
        end

        // Reading status while an access is still in flight marks it busy.
        if (state == CAP_DR && sel_dmi && sticky_rsp == 2'd0 && outst_rsp) begin
            sticky_next = 2'd3;
        end

        if (state == UPD_DR && sel_dmi && sticky_rsp == 2'd0 &&
            (upd_op == 2'd1 || upd_op == 2'd2)) begin
            if (outst_rsp) begin
                sticky_next = 2'd3;
            end else begin
                req_valid_next   = 1'b1;
                req_addr_next    = sr[DMI_W-1:34];
                req_data_next    = sr[33:2];
                req_op_next      = upd_op;
                outstanding_next = 1'b1;
            end
        end

        if (state == UPD_DR && sel_dtmcs) begin
            if (sr[16]) begin
                reset_pulse_next = 1'b1;
                sticky_next      = 2'd0;
            end
            // Hard reset also discards any response arriving this cycle.
            if (sr[17]) begin
                hard_pulse_next  = 1'b1;
                sticky_next      = 2'd0;
                outstanding_next = 1'b0;
                req_valid_next   = 1'b0;
                rsp_data_next    = rsp_data_q;
            end
        end
    end

    always_ff @(posedge tck) begin
        if (trst) begin
            state          <= TLR;
            ir             <= IR_WIDTH'(1);
            sr             <= '0;
            sticky         <= 2'd0;
            outstanding    <= 1'b0;
            rsp_data_q     <= '0;
            dmi_req_valid  <= 1'b0;
            dmi_req_addr   <= '0;
            dmi_req_data   <= '0;
            dmi_req_op     <= 2'd0;
            dmi_reset      <= 1'b0;
            dmi_hard_reset <= 1'b0;
        end else begin
            state          <= state_next;
            ir             <= ir_next;
            sr             <= sr_next;
            sticky         <= sticky_next;
            outstanding    <= outstanding_next;
            rsp_data_q     <= rsp_data_next;
            dmi_req_valid  <= req_valid_next;
            dmi_req_addr   <= req_addr_next;
            dmi_req_data   <= req_data_next;
            dmi_req_op     <= req_op_next;
            dmi_reset      <= reset_pulse_next;
            dmi_hard_reset <= hard_pulse_next;
        end
    end

    // Falling-edge retiming; sr is cleared by reset so tdo follows to 0.
    always_ff @(negedge tck) begin
        tdo <= sr[0];
    end

endmodule

// File: tb/tb_rvjtag_tap_dmi_gen.sv
// Directed testbench for rvjtag_tap_dmi_gen: drives JTAG sequences and a
// simple DMI responder, comparing against hand-computed values.
module tb_rvjtag_tap_dmi_gen;

    logic        tck = 1'b0;
    logic        trst, tms, tdi;
    logic        tdo, tdo_en;
    logic [2:0]  idle_hint;
    logic        dmi_req_valid, dmi_req_ready;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic [1:0]  dmi_req_op;
    logic        dmi_rsp_valid;
    logic [31:0] dmi_rsp_data;
    logic [1:0]  dmi_rsp_status;
    logic        dmi_reset, dmi_hard_reset;

    int checks = 0;
    int errors = 0;

    rvjtag_tap_dmi_gen dut (
        .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
        .idle_hint(idle_hint),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
        .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_data(dmi_rsp_data),
        .dmi_rsp_status(dmi_rsp_status),
        .dmi_reset(dmi_reset), .dmi_hard_reset(dmi_hard_reset)
    );

    always #5 tck = ~tck;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One tck cycle: sample tdo/tdo_en after the falling edge, then drive tms/tdi.
    task automatic applyStimulus(input logic m, input logic d, output logic o, output logic en);
        @(negedge tck);
        #1;
        o   = tdo;
        en  = tdo_en;
        tms = m;
        tdi = d;
        @(posedge tck);
        #1;
    endtask

    task automatic idle(input int n);
        logic o, e;
        repeat (n) applyStimulus(1'b0, 1'b0, o, e);
    endtask

    task automatic shift_ir(input logic [4:0] v);
        logic o, e;
        logic [4:0] d;
        d = v;
        applyStimulus(1'b1, 1'b0, o, e);
        applyStimulus(1'b1, 1'b0, o, e);
        applyStimulus(1'b0, 1'b0, o, e);
        applyStimulus(1'b0, 1'b0, o, e);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i == 4, d[0], o, e);
            d = d >> 1;
        end
        applyStimulus(1'b1, 1'b0, o, e);
        applyStimulus(1'b0, 1'b0, o, e);
    endtask

    task automatic shift_dr(input int len, input logic [63:0] din,
                            output logic [63:0] dout, output logic en_all);
        logic o, e;
        logic [63:0] d;
        d      = din;
        dout   = '0;
        en_all = 1'b1;
        applyStimulus(1'b1, 1'b0, o, e);
        applyStimulus(1'b0, 1'b0, o, e);
        applyStimulus(1'b0, 1'b0, o, e);
        for (int i = 0; i < len; i++) begin
            applyStimulus(i == len - 1, d[0], o, e);
            d      = d >> 1;
            dout   = dout | (64'(o) << i);
            en_all = en_all & e;
        end
        applyStimulus(1'b1, 1'b0, o, e);
        applyStimulus(1'b0, 1'b0, o, e);
    endtask

    task automatic respond(input logic [31:0] data, input logic [1:0] status);
        dmi_rsp_valid  = 1'b1;
        dmi_rsp_data   = data;
        dmi_rsp_status = status;
        idle(1);
        dmi_rsp_valid  = 1'b0;
        dmi_rsp_data   = '0;
        dmi_rsp_status = 2'd0;
    endtask

    localparam logic [63:0] DTMCS_BASE = 64'h5071;

    initial begin
        logic [63:0] out;
        logic en, o, e;

        trst = 1'b1; tms = 1'b1; tdi = 1'b0; idle_hint = 3'd5;
        dmi_req_ready = 1'b0; dmi_rsp_valid = 1'b0; dmi_rsp_data = '0; dmi_rsp_status = 2'd0;

        // Reset state
        repeat (3) applyStimulus(1'b1, 1'b0, o, e);
        checkOutput("reset_tdo", 64'(o), 64'h0);
        checkOutput("reset_valid", 64'(dmi_req_valid), 64'h0);
        checkOutput("reset_dmireset", 64'(dmi_reset), 64'h0);
        checkOutput("reset_hardreset", 64'(dmi_hard_reset), 64'h0);
        trst = 1'b0;
        idle(1);

        // IDCODE selected after reset
        shift_dr(32, 64'h0, out, en);
        checkOutput("idcode", out, 64'h1);
        checkOutput("tdo_en_shift", 64'(en), 64'h1);
        checkOutput("tdo_en_idle", 64'(tdo_en), 64'h0);

        // BYPASS: one-bit delay
        shift_ir(5'h1F);
        shift_dr(8, 64'hA5, out, en);
        checkOutput("bypass", out, 64'h4A);

        // DMI write with ready held low three cycles
        shift_ir(5'h11);
        shift_dr(41, {23'b0, 7'h10, 32'hDEADBEEF, 2'd2}, out, en);
        checkOutput("dmi_cap_initial", out, 64'h0);
        checkOutput("wr_valid", 64'(dmi_req_valid), 64'h1);
        for (int c = 0; c < 3; c++) begin
            idle(1);
            checkOutput("wr_valid_hold", 64'(dmi_req_valid), 64'h1);
            checkOutput("wr_addr", 64'(dmi_req_addr), 64'h10);
            checkOutput("wr_data", 64'(dmi_req_data), 64'hDEADBEEF);
            checkOutput("wr_op", 64'(dmi_req_op), 64'h2);
        end
        dmi_req_ready = 1'b1;
        idle(1);
        dmi_req_ready = 1'b0;
        checkOutput("wr_valid_drop", 64'(dmi_req_valid), 64'h0);
        respond(32'hFFFF_FFFF, 2'd0);
        shift_ir(5'h10);
        shift_dr(32, 64'h0, out, en);
        checkOutput("dtmcs_after_wr", out, DTMCS_BASE);

        // Read with no response, then a second read gets busy
        shift_ir(5'h11);
        dmi_req_ready = 1'b1;
        shift_dr(41, {23'b0, 7'h05, 32'h0, 2'd1}, out, en);
        checkOutput("dmi_cap_wr_not_latched", out, 64'h0);
        checkOutput("rd1_valid", 64'(dmi_req_valid), 64'h1);
        checkOutput("rd1_op", 64'(dmi_req_op), 64'h1);
        idle(1);
        checkOutput("rd1_accepted", 64'(dmi_req_valid), 64'h0);
        shift_dr(41, {23'b0, 7'h06, 32'h0, 2'd1}, out, en);
        checkOutput("dmi_cap_busy", out, 64'h3);
        idle(2);
        checkOutput("rd2_dropped", 64'(dmi_req_valid), 64'h0);
        dmi_req_ready = 1'b0;
        shift_ir(5'h10);
        shift_dr(32, 64'h0, out, en);
        checkOutput("dtmcs_busy", out, DTMCS_BASE | 64'hC00);
        respond(32'hCAFE_F00D, 2'd0);
        shift_dr(32, 64'h1_0000, out, en);
        checkOutput("dtmcs_busy_again", out, DTMCS_BASE | 64'hC00);
        checkOutput("dmireset_pulse", 64'(dmi_reset), 64'h1);
        checkOutput("dmireset_no_hard", 64'(dmi_hard_reset), 64'h0);
        idle(1);
        checkOutput("dmireset_single", 64'(dmi_reset), 64'h0);
        shift_dr(32, 64'h0, out, en);
        checkOutput("dtmcs_cleared", out, DTMCS_BASE);
        shift_ir(5'h11);
        dmi_req_ready = 1'b1;
        shift_dr(41, {23'b0, 7'h07, 32'h0, 2'd1}, out, en);
        checkOutput("dmi_cap_rd_data", out, {23'b0, 7'h0, 32'hCAFEF00D, 2'd0});
        checkOutput("rd3_valid", 64'(dmi_req_valid), 64'h1);
        checkOutput("rd3_addr", 64'(dmi_req_addr), 64'h07);
        idle(1);
        dmi_req_ready = 1'b0;

        // Failed read makes status sticky
        respond(32'h1234_5678, 2'd2);
        shift_dr(41, {23'b0, 7'h08, 32'h0, 2'd1}, out, en);
        checkOutput("dmi_cap_failed", out, {23'b0, 7'h0, 32'h12345678, 2'd2});
        idle(2);
        checkOutput("failed_op_ignored", 64'(dmi_req_valid), 64'h0);
        shift_dr(41, {23'b0, 7'h08, 32'h0, 2'd1}, out, en);
        checkOutput("dmi_cap_failed_sticky", out, {23'b0, 7'h0, 32'h12345678, 2'd2});
        shift_ir(5'h10);
        shift_dr(32, 64'h0, out, en);
        checkOutput("dtmcs_failed", out, DTMCS_BASE | 64'h800);
        shift_dr(32, 64'h1_0000, out, en);
        shift_dr(32, 64'h0, out, en);
        checkOutput("dtmcs_failed_cleared", out, DTMCS_BASE);

        // Hard reset while a read is outstanding; late response ignored
        shift_ir(5'h11);
        dmi_req_ready = 1'b1;
        shift_dr(41, {23'b0, 7'h09, 32'h0, 2'd1}, out, en);
        checkOutput("dmi_cap_ok", out, {23'b0, 7'h0, 32'h12345678, 2'd0});
        idle(1);
        checkOutput("rd4_accepted", 64'(dmi_req_valid), 64'h0);
        dmi_req_ready = 1'b0;
        shift_ir(5'h10);
        shift_dr(32, 64'h2_0000, out, en);
        checkOutput("dtmcs_before_hard", out, DTMCS_BASE);
        checkOutput("hard_pulse", 64'(dmi_hard_reset), 64'h1);
        checkOutput("hard_no_dmireset", 64'(dmi_reset), 64'h0);
        idle(1);
        checkOutput("hard_single", 64'(dmi_hard_reset), 64'h0);
        respond(32'hBBBB_BBBB, 2'd3);
        shift_ir(5'h11);
        shift_dr(41, {23'b0, 7'h0A, 32'h0, 2'd1}, out, en);
        checkOutput("dmi_cap_late_ignored", out, {23'b0, 7'h0, 32'h12345678, 2'd0});
        checkOutput("rd5_valid", 64'(dmi_req_valid), 64'h1);
        checkOutput("rd5_addr", 64'(dmi_req_addr), 64'h0A);

        // trst aborts the pending request and restores IDCODE
        trst = 1'b1;
        idle(1);
        checkOutput("trst_abort", 64'(dmi_req_valid), 64'h0);
        trst = 1'b0;
        idle(1);
        shift_dr(32, 64'h0, out, en);
        checkOutput("idcode_after_trst", out, 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
